// File: rtl/enemy_pkg.sv
// Shared types for the enemy controller: walk directions, life and probe states.
package enemy_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    UP    = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    INACTIVE  = 2'd0,
    ALIVE     = 2'd1,
    KNOCKBACK = 2'd2,
    DYING     = 2'd3
  } life_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PROBE_A = 2'd1,
    PROBE_B = 2'd2,
    COMMIT  = 2'd3
  } probe_t;

  localparam int unsigned CW = 8;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      LEFT:    opposite = RIGHT;
      RIGHT:   opposite = LEFT;
      DOWN:    opposite = UP;
      default: opposite = DOWN;
    endcase
  endfunction

endpackage

// File: rtl/frame_edge_det.sv
// One-Clk pulse on each rising edge of the vsync-rate frame tick.
module frame_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= 1'b0;
    else       prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/level_rom.sv
// Room collision lookup: screen border walls plus one pillar in every room except 0.
module level_rom (
  input  logic [2:0] room,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       is_wall
);

  logic [9:0] px;
  logic       border;
  logic       pillar;

  assign px     = {1'b0, room, 6'b0} + 10'd128;
  assign border = (x < 10'd16) || (x >= 10'd608) || (y < 10'd16) || (y >= 10'd448);
  assign pillar = (room != 3'd0) && (x >= px) && (x < px + 10'd16) &&
                  (y >= 10'd128) && (y < 10'd320);
  assign is_wall = border || pillar;

endmodule

// File: rtl/enemy_unit.sv
// Enemy sprite controller: life FSM, hit/knockback/death timers and a
// four-step wall-probe sequencer that commits one move per frame tick.
module enemy_unit
  import enemy_pkg::*;
#(
  parameter logic [9:0]  X_START       = 10'd700,
  parameter logic [9:0]  Y_START       = 10'd600,
  parameter logic [9:0]  STEP          = 10'd2,
  parameter logic [9:0]  SIZE          = 10'd32,
  parameter int unsigned HP_MAX        = 3,
  parameter logic [9:0]  KNOCK_STEP    = 10'd4,
  parameter int unsigned KNOCK_FRAMES  = 8,
  parameter int unsigned INVULN_FRAMES = 16,
  parameter int unsigned DEATH_FRAMES  = 12
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       initialize,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic       damage,
  input  logic [1:0] dir,
  input  logic [2:0] room,
  output logic [9:0] Enemy_X,
  output logic [9:0] Enemy_Y,
  output logic       active,
  output logic [2:0] hp,
  output logic       flash
);

  localparam logic [2:0]    HP_INIT = 3'(HP_MAX);
  localparam logic [CW-1:0] INV_INIT = CW'(INVULN_FRAMES);
  localparam logic [CW-1:0] KNK_INIT = CW'(KNOCK_FRAMES);
  localparam logic [CW-1:0] DTH_INIT = CW'(DEATH_FRAMES);

  life_t         life_q, life_d;
  probe_t        probe_q, probe_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [9:0]    cx_q, cx_d, cy_q, cy_d;
  logic [2:0]    hp_q, hp_d;
  logic [CW-1:0] inv_q, inv_d, knock_q, knock_d, death_q, death_d;
  dir_t          kdir_q, kdir_d, mdir_q, mdir_d;
  logic          mknock_q, mknock_d;
  logic          pend_q, pend_d;
  logic          wall_q, wall_d;

  logic          fedge;
  logic          live;
  logic          hit_req;
  dir_t          sdir;
  logic [9:0]    sstep;
  logic [9:0]    probe_x, probe_y;
  logic          rom_wall;

  frame_edge_det u_edge (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .sig_i  (frame_clk),
    .rise_o (fedge)
  );

  // PROBE_A and PROBE_B share one lookup; the two leading corners depend on the latched direction.
  always_comb begin
    if (probe_q == PROBE_B) begin
      probe_x = (mdir_q == LEFT) ? cx_q : cx_q + SIZE;
      probe_y = (mdir_q == UP)   ? cy_q : cy_q + SIZE;
    end else begin
      probe_x = (mdir_q == RIGHT) ? cx_q + SIZE : cx_q;
      probe_y = (mdir_q == DOWN)  ? cy_q + SIZE : cy_q;
    end
  end

  level_rom u_rom (
    .room    (room),
    .x       (probe_x),
    .y       (probe_y),
    .is_wall (rom_wall)
  );

  assign live    = (life_q == ALIVE) || (life_q == KNOCKBACK);
  assign hit_req = pend_q | damage;
  assign sdir    = (life_q == KNOCKBACK) ? kdir_q : dir_t'(dir);
  assign sstep   = (life_q == KNOCKBACK) ? KNOCK_STEP : STEP;

  always_comb begin
    life_d   = life_q;
    probe_d  = probe_q;
    x_d      = x_q;
    y_d      = y_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    hp_d     = hp_q;
    inv_d    = inv_q;
    knock_d  = knock_q;
    death_d  = death_q;
    kdir_d   = kdir_q;
    mdir_d   = mdir_q;
    mknock_d = mknock_q;
    pend_d   = pend_q | damage;
    wall_d   = wall_q;

    if (initialize) begin
      x_d     = spawn_x;
      y_d     = spawn_y;
      hp_d    = HP_INIT;
      inv_d   = '0;
      knock_d = '0;
      death_d = '0;
      pend_d  = 1'b0;
      wall_d  = 1'b0;
      life_d  = ALIVE;
      probe_d = IDLE;
    end else begin
      // A probe in flight when the enemy stops being live is abandoned without committing.
      if (!live) begin
        probe_d = IDLE;
      end else begin
        case (probe_q)
          IDLE: begin
            if (fedge) begin
              probe_d  = PROBE_A;
              mdir_d   = sdir;
              mknock_d = (life_q == KNOCKBACK);
              cx_d     = x_q;
              cy_d     = y_q;
              case (sdir)
                LEFT:    cx_d = x_q - sstep;
                RIGHT:   cx_d = x_q + sstep;
                DOWN:    cy_d = y_q + sstep;
                default: cy_d = y_q - sstep;
              endcase
            end
          end
          PROBE_A: begin
            wall_d  = rom_wall;
            probe_d = PROBE_B;
          end
          PROBE_B: begin
            wall_d  = wall_q | rom_wall;
            probe_d = COMMIT;
          end
          default: begin
            probe_d = IDLE;
            if (!wall_q) begin
              x_d = cx_q;
              y_d = cy_q;
            end else if (!mknock_q) begin
              case (mdir_q)
                LEFT:    x_d = x_q + 10'd1;
                RIGHT:   x_d = x_q - 10'd1;
                DOWN:    y_d = y_q - 10'd1;
                default: y_d = y_q + 10'd1;
              endcase
            end
          end
        endcase
      end

      if (fedge) begin
        pend_d  = 1'b0;
        inv_d   = (inv_q   != '0) ? inv_q   - 1'b1 : '0;
        knock_d = (knock_q != '0) ? knock_q - 1'b1 : '0;
        death_d = (death_q != '0) ? death_q - 1'b1 : '0;
        if (hit_req && live && (inv_q == '0)) begin
          hp_d    = hp_q - 3'd1;
          inv_d   = INV_INIT;
          knock_d = KNK_INIT;
          kdir_d  = opposite(dir_t'(dir));
          if (hp_q <= 3'd1) begin
            life_d  = DYING;
            death_d = DTH_INIT;
          end else begin
            life_d  = KNOCKBACK;
          end
        end else if (life_q == KNOCKBACK) begin
          if (knock_q <= 1) life_d = ALIVE;
        end else if (life_q == DYING) begin
          if (death_q <= 1) begin
            life_d = INACTIVE;
            x_d    = X_START;
            y_d    = Y_START;
            hp_d   = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      life_q   <= INACTIVE;
      probe_q  <= IDLE;
      x_q      <= X_START;
      y_q      <= Y_START;
      cx_q     <= '0;
      cy_q     <= '0;
      hp_q     <= '0;
      inv_q    <= '0;
      knock_q  <= '0;
      death_q  <= '0;
      kdir_q   <= LEFT;
      mdir_q   <= LEFT;
      mknock_q <= 1'b0;
      pend_q   <= 1'b0;
      wall_q   <= 1'b0;
    end else begin
      life_q   <= life_d;
      probe_q  <= probe_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      hp_q     <= hp_d;
      inv_q    <= inv_d;
      knock_q  <= knock_d;
      death_q  <= death_d;
      kdir_q   <= kdir_d;
      mdir_q   <= mdir_d;
      mknock_q <= mknock_d;
      pend_q   <= pend_d;
      wall_q   <= wall_d;
    end
  end

  assign Enemy_X = x_q;
  assign Enemy_Y = y_q;
  assign active  = live;
  assign hp      = hp_q;
  assign flash   = (inv_q != '0);

endmodule
